// File: rtl/ga_crossover.sv
// ga_crossover: single-point crossover stage between parent selection and mutation.
//
// Accepts one parent pair per parents_valid/parents_ack handshake. At capture it
// samples rand_data as the crossover point, reduces that point modulo the active
// chromosome length, and then presents two children, one at a time, on a
// child_valid/child_ack handshake. It counts the children delivered in the current
// generation and pulses children_done_pls once cnfg_p children have gone out.
//
// Ports:
//   clk                clock
//   sw_rst             synchronous reset, active-high, highest priority
//   cnfg_p             children per generation (1..P_MAX)
//   cnfg_chrom_len     active chromosome length (2..CHROM_MAX_W)
//   cnfg_xover_en      0 = bypass, children are masked copies of the parents
//   new_gen_start_pls  clears the child counter; leaves the generation-done state
//   rand_data          random source, sampled when a pair is captured
//   parents_valid      parent pair available, held until parents_ack
//   parent1, parent2   parent chromosomes
//   parents_ack        one-cycle pulse: pair consumed
//   child_valid        child available, held until child_ack
//   child_chrom        child chromosome, stable while child_valid is high
//   child_ack          downstream accepts the child
//   children_done_pls  one-cycle pulse: cnfg_p children delivered
module ga_crossover #(
  parameter int unsigned CHROM_MAX_W = 128,
  parameter int unsigned LEN_W       = $clog2(CHROM_MAX_W + 1),
  parameter int unsigned RAND_W      = $clog2(CHROM_MAX_W) + 2,
  parameter int unsigned P_MAX       = 1024,
  parameter int unsigned P_MAX_W     = $clog2(P_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   sw_rst,
  input  logic [P_MAX_W-1:0]     cnfg_p,
  input  logic [LEN_W-1:0]       cnfg_chrom_len,
  input  logic                   cnfg_xover_en,
  input  logic                   new_gen_start_pls,
  input  logic [RAND_W-1:0]      rand_data,
  input  logic                   parents_valid,
  input  logic [CHROM_MAX_W-1:0] parent1,
  input  logic [CHROM_MAX_W-1:0] parent2,
  output logic                   parents_ack,
  output logic                   child_valid,
  output logic [CHROM_MAX_W-1:0] child_chrom,
  input  logic                   child_ack,
  output logic                   children_done_pls
);

  typedef enum logic [2:0] {
    StIdle,
    StReduce,
    StChild1,
    StChild2,
    StGenDone
  } state_e;

  state_e                 state_q;
  logic [CHROM_MAX_W-1:0] p1_q;
  logic [CHROM_MAX_W-1:0] p2_q;
  logic [CHROM_MAX_W-1:0] child2_q;
  logic [RAND_W-1:0]      pt_q;
  logic [P_MAX_W-1:0]     cnt_q;

  logic [RAND_W-1:0]      len_ext;
  logic                   pt_ge_len;
  logic [CHROM_MAX_W-1:0] pt_mask;
  logic [CHROM_MAX_W-1:0] len_mask;
  logic [CHROM_MAX_W-1:0] child1_c;
  logic [CHROM_MAX_W-1:0] child2_c;
  logic [P_MAX_W-1:0]     cnt_inc;
  logic                   cnt_hit;

  // RAND_W always exceeds LEN_W, so the length zero-extends into the point width.
  assign len_ext   = {{(RAND_W - LEN_W){1'b0}}, cnfg_chrom_len};
  assign pt_ge_len = (pt_q >= len_ext);
  assign cnt_inc   = cnt_q + 1'b1;
  assign cnt_hit   = (cnt_inc == cnfg_p);

  // pt_mask selects bits below the crossover point, len_mask the active length.
  always_comb begin
    pt_mask  = '0;
    len_mask = '0;
    for (int i = 0; i < int'(CHROM_MAX_W); i++) begin
      pt_mask[i]  = (i < int'(pt_q));
      len_mask[i] = (i < int'(cnfg_chrom_len));
    end
  end

  always_comb begin
    child1_c = '0;
    child2_c = '0;
    if (cnfg_xover_en) begin
      child1_c = ((p1_q & pt_mask) | (p2_q & ~pt_mask)) & len_mask;
      child2_c = ((p2_q & pt_mask) | (p1_q & ~pt_mask)) & len_mask;
    end else begin
      child1_c = p1_q & len_mask;
      child2_c = p2_q & len_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q           <= StIdle;
      p1_q              <= '0;
      p2_q              <= '0;
      child2_q          <= '0;
      pt_q              <= '0;
      cnt_q             <= '0;
      parents_ack       <= 1'b0;
      child_valid       <= 1'b0;
      child_chrom       <= '0;
      children_done_pls <= 1'b0;
    end else begin
      parents_ack       <= 1'b0;
      children_done_pls <= 1'b0;
      case (state_q)
        StIdle: begin
          if (parents_valid) begin
            p1_q        <= parent1;
            p2_q        <= parent2;
            pt_q        <= rand_data;
            parents_ack <= 1'b1;
            state_q     <= StReduce;
          end
        end
        StReduce: begin
          // One subtraction per cycle keeps the datapath to a single comparator.
          if (pt_ge_len) begin
            pt_q <= pt_q - len_ext;
          end else begin
            child_chrom <= child1_c;
            child2_q    <= child2_c;
            child_valid <= 1'b1;
            state_q     <= StChild1;
          end
        end
        StChild1: begin
          if (child_ack) begin
            cnt_q <= cnt_inc;
            if (cnt_hit) begin
              // Odd generation size: the second child is discarded.
              child_valid       <= 1'b0;
              children_done_pls <= 1'b1;
              state_q           <= StGenDone;
            end else begin
              child_chrom <= child2_q;
              state_q     <= StChild2;
            end
          end
        end
        StChild2: begin
          if (child_ack) begin
            cnt_q       <= cnt_inc;
            child_valid <= 1'b0;
            if (cnt_hit) begin
              children_done_pls <= 1'b1;
              state_q           <= StGenDone;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StGenDone: begin
          if (new_gen_start_pls) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      // A generation restart overrides any same-cycle count increment.
      if (new_gen_start_pls) begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ga_crossover.sv
// Directed self-checking bench for ga_crossover: basic crossover, modulo reduction,
// bypass masking, backpressure, odd generation size and reset mid-transfer.
module tb_ga_crossover;

  localparam int unsigned CW = 128;

  logic          clk;
  logic          sw_rst;
  logic [10:0]   cnfg_p;
  logic [7:0]    cnfg_chrom_len;
  logic          cnfg_xover_en;
  logic          new_gen_start_pls;
  logic [8:0]    rand_data;
  logic          parents_valid;
  logic [CW-1:0] parent1;
  logic [CW-1:0] parent2;
  logic          parents_ack;
  logic          child_valid;
  logic [CW-1:0] child_chrom;
  logic          child_ack;
  logic          children_done_pls;

  int n_checks = 0;
  int n_errors = 0;

  ga_crossover dut (
    .clk               (clk),
    .sw_rst            (sw_rst),
    .cnfg_p            (cnfg_p),
    .cnfg_chrom_len    (cnfg_chrom_len),
    .cnfg_xover_en     (cnfg_xover_en),
    .new_gen_start_pls (new_gen_start_pls),
    .rand_data         (rand_data),
    .parents_valid     (parents_valid),
    .parent1           (parent1),
    .parent2           (parent2),
    .parents_ack       (parents_ack),
    .child_valid       (child_valid),
    .child_chrom       (child_chrom),
    .child_ack         (child_ack),
    .children_done_pls (children_done_pls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input string tag, input logic [CW-1:0] p1, input logic [CW-1:0] p2,
                           input logic [8:0] r);
    int n;
    parent1       = p1;
    parent2       = p2;
    rand_data     = r;
    parents_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!parents_ack && n < 50);
    parents_valid = 1'b0;
    check({tag, "_ack_lat"}, CW'(n), CW'(1));
  endtask

  task automatic get_child(input string tag, input logic [CW-1:0] exp, input int exp_wait,
                           input logic exp_done);
    int n;
    n = 0;
    while (!child_valid && n < 400) begin
      step();
      n++;
    end
    check({tag, "_lat"}, CW'(n), CW'(exp_wait));
    check({tag, "_chrom"}, child_chrom, exp);
    child_ack = 1'b1;
    step();
    child_ack = 1'b0;
    check({tag, "_done"}, CW'(children_done_pls), CW'(exp_done));
  endtask

  initial begin
    int n;
    int acks;
    sw_rst            = 1'b1;
    cnfg_p            = 11'd100;
    cnfg_chrom_len    = 8'd8;
    cnfg_xover_en     = 1'b1;
    new_gen_start_pls = 1'b0;
    rand_data         = '0;
    parents_valid     = 1'b0;
    parent1           = '0;
    parent2           = '0;
    child_ack         = 1'b0;
    step();
    step();
    sw_rst = 1'b0;
    check("rst_ack", CW'(parents_ack), CW'(0));
    check("rst_valid", CW'(child_valid), CW'(0));
    check("rst_chrom", child_chrom, CW'(0));
    check("rst_done", CW'(children_done_pls), CW'(0));

    // Basic crossover at point 3.
    send_pair("s1", CW'('hFF), CW'('h00), 9'd3);
    get_child("s1c1", CW'('h07), 1, 1'b0);
    get_child("s1c2", CW'('hF8), 0, 1'b0);
    check("s1_valid_drop", CW'(child_valid), CW'(0));

    // 19 mod 8 = 3: same children, two extra reduction cycles.
    send_pair("s2", CW'('hFF), CW'('h00), 9'd19);
    get_child("s2c1", CW'('h07), 3, 1'b0);
    get_child("s2c2", CW'('hF8), 0, 1'b0);

    // Bypass with length masking.
    cnfg_xover_en  = 1'b0;
    cnfg_chrom_len = 8'd5;
    send_pair("s3", CW'('hAB), CW'('h3C), 9'd2);
    get_child("s3c1", CW'('h0B), 1, 1'b0);
    get_child("s3c2", CW'('h1C), 0, 1'b0);

    // Backpressure: child held stable for 6 cycles.
    cnfg_xover_en  = 1'b1;
    cnfg_chrom_len = 8'd8;
    send_pair("s5", CW'('hAA), CW'('h55), 9'd4);
    n = 0;
    while (!child_valid && n < 50) begin
      step();
      n++;
    end
    check("s5_lat", CW'(n), CW'(1));
    for (int i = 0; i < 6; i++) begin
      step();
      check("s5_hold_valid", CW'(child_valid), CW'(1));
      check("s5_hold_chrom", child_chrom, CW'('h5A));
      check("s5_hold_ack", CW'(parents_ack), CW'(0));
    end
    get_child("s5c1", CW'('h5A), 0, 1'b0);
    get_child("s5c2", CW'('hA5), 0, 1'b0);

    // Odd generation size of 3.
    new_gen_start_pls = 1'b1;
    step();
    new_gen_start_pls = 1'b0;
    cnfg_p = 11'd3;
    send_pair("s4a", CW'('hFF), CW'('h00), 9'd3);
    get_child("s4a1", CW'('h07), 1, 1'b0);
    get_child("s4a2", CW'('hF8), 0, 1'b0);
    send_pair("s4b", CW'('h0F), CW'('hF0), 9'd4);
    get_child("s4b1", CW'('hFF), 1, 1'b1);
    check("s4_valid_drop", CW'(child_valid), CW'(0));
    step();
    check("s4_done_once", CW'(children_done_pls), CW'(0));
    parent1       = CW'('hAA);
    parent2       = CW'('h55);
    rand_data     = 9'd4;
    parents_valid = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      acks += int'(parents_ack);
    end
    check("s4_no_ack_done", CW'(acks), CW'(0));
    check("s4_no_child", CW'(child_valid), CW'(0));
    new_gen_start_pls = 1'b1;
    step();
    new_gen_start_pls = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!parents_ack && n < 20);
    parents_valid = 1'b0;
    check("s4_restart_ack", CW'(n), CW'(1));
    get_child("s4c1", CW'('h5A), 1, 1'b0);
    get_child("s4c2", CW'('hA5), 0, 1'b0);

    // Reset while the first child is pending; counter was at 2 of 3.
    send_pair("s6", CW'('hAA), CW'('h55), 9'd4);
    n = 0;
    while (!child_valid && n < 50) begin
      step();
      n++;
    end
    check("s6_lat", CW'(n), CW'(1));
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    check("s6_valid", CW'(child_valid), CW'(0));
    check("s6_chrom", child_chrom, CW'(0));
    send_pair("s6a", CW'('hFF), CW'('h00), 9'd3);
    get_child("s6a1", CW'('h07), 1, 1'b0);
    get_child("s6a2", CW'('hF8), 0, 1'b0);
    send_pair("s6b", CW'('h0F), CW'('hF0), 9'd4);
    get_child("s6b1", CW'('hFF), 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
